button_chord_debounce: RTL and testbench
========================================

BUTTON_CHORD_DEBOUNCE -- requirements
Module: button_chord_debounce

Interface
REQ-001 Parameter SETTLE_CYCLES, default 500000, meaning consecutive unchanged synchronized cycles before a press pattern is accepted.
REQ-002 Parameter RELEASE_CYCLES, default 500000, meaning consecutive all-zero synchronized cycles before a release is accepted.
REQ-003 Parameter CNT_W, default 20, meaning width of the shared cycle counter; it SHALL hold max(SETTLE_CYCLES, RELEASE_CYCLES)-1.
REQ-004 clk  input  1  single rising-edge clock for all state.
REQ-005 clear_n  input  1  asynchronous, active-low reset.
REQ-006 btn_raw  input  10  raw asynchronous push-buttons, active-high; bit n is digit key n.
REQ-007 button  output  10  registered accepted pattern; non-zero for exactly one cycle per accepted press; drives the calculator FSM button input.
REQ-008 btn_valid  output  1  registered one-cycle strobe, high exactly when button is non-zero.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 err  output  1  one-cycle strobe on a rejected pattern (see Configuration).

Function
REQ-011 btn_raw SHALL pass through a 2-flop synchronizer; the second stage is called s.
REQ-012 FSM states SHALL be IDLE, ARM, EMIT and RELEASE, with one counter cnt and one 10-bit register snap.
REQ-013 IDLE: if s is non-zero, go to ARM with snap set to s and cnt set to 0; otherwise stay.
REQ-014 ARM: if s is 0, go to IDLE with no output (bounce rejected).
REQ-015 ARM: if s is non-zero and differs from snap, set snap to s and cnt to 0, and stay (chord growing or shrinking restarts the settle window).
REQ-016 ARM: if s equals snap, increment cnt; when cnt equals SETTLE_CYCLES-1, go to EMIT.
REQ-017 On entering EMIT, register button set to snap and btn_valid set to 1 for exactly one cycle; then go to RELEASE unconditionally.
REQ-018 RELEASE: any non-zero s sets cnt to 0; s equal to 0 increments cnt; when cnt equals RELEASE_CYCLES-1, go to IDLE. No output is produced in RELEASE.
REQ-019 Latency: if the first clock edge sampling the final stable pattern into the synchronizer is edge k, then button/btn_valid SHALL be high in the cycle following edge k+SETTLE_CYCLES+2 and low in every other cycle.
REQ-020 A held key SHALL never produce a second pulse (no auto-repeat); a new pulse requires a completed RELEASE.
REQ-021 Outside the EMIT cycle, button SHALL be 0 and btn_valid SHALL be 0.
REQ-022 The counter SHALL saturate and never wrap; cnt is reset to 0 on every state transition.

Reset
REQ-023 When clear_n is low: state is IDLE, synchronizer, snap and cnt are 0, and button=0, btn_valid=0, busy=0, err=0, asynchronously.
REQ-024 Reset asserted mid-ARM or mid-RELEASE SHALL discard the pending pattern; no pulse is emitted after deassertion unless a full new press completes.

Configuration
REQ-025 Macro BTN_CHORD_VALIDATE_EN.
REQ-026 With BTN_CHORD_VALIDATE_EN defined, EMIT SHALL output snap only if it is a legal code: a one-hot digit, 0x201, 0x202, 0x204, 0x208, 0x300 or 0x380. Otherwise button stays 0, btn_valid stays 0, err pulses for one cycle, and the FSM still goes to RELEASE.
REQ-027 Without BTN_CHORD_VALIDATE_EN, any non-zero settled pattern SHALL be emitted, and err SHALL be constant 0.

Verification (SETTLE_CYCLES=4, RELEASE_CYCLES=4)
REQ-028 btn_raw=0x004 held 20 cycles, then 0 for 10 cycles -> exactly one cycle of button=0x004 with btn_valid=1, at latency per REQ-019; busy returns to 0.
REQ-029 btn_raw=0x200 for 2 cycles, then 0x208 held 20 cycles -> a single pulse of button=0x208 only; 0x200 is never emitted.
REQ-030 btn_raw toggling 0x001/0x000 every cycle for 30 cycles -> no pulse, and the FSM oscillates between IDLE and ARM.
REQ-031 btn_raw=0x380 held 50 cycles -> exactly one pulse of 0x380; release for 3 cycles, re-press, release 10 cycles -> no second pulse until the re-press after a full release.
REQ-032 clear_n low for 1 cycle during ARM with 0x010 pressed -> outputs are 0 immediately; the press is re-settled from IDLE, and exactly one pulse follows.
REQ-033 With BTN_CHORD_VALIDATE_EN, btn_raw=0x003 held -> err pulses once, button stays 0. Without the macro -> button=0x003 pulses once.

Source files
------------

// File: rtl/button_chord_debounce.sv
// ============================================================================
// Module   : button_chord_debounce
// Purpose  : Debounces a 10-key push-button bank. Emits one registered pulse
//            for each settled press pattern, which may be a single key or a
//            chord. Optional macro BTN_CHORD_VALIDATE_EN rejects chords that
//            are not legal codes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_chord_debounce #(
    parameter int SETTLE_CYCLES  = 500000,
    parameter int RELEASE_CYCLES = 500000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [9:0] btn_raw,
    output logic [9:0] button,
    output logic       btn_valid,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_EMIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX      = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [9:0]       snap_q, snap_d;
    logic [9:0]       sync1_q, sync1_d;
    logic [9:0]       s_q, s_d;
    logic [9:0]       button_q, button_d;
    logic             btn_valid_q, btn_valid_d;

`ifdef BTN_CHORD_VALIDATE_EN
    logic             err_q, err_d;

    function automatic logic legal_code(input logic [9:0] p);
        logic one_hot;
        one_hot = (p != 10'h000) && ((p & (p - 10'h001)) == 10'h000);
        case (p)
            10'h201, 10'h202, 10'h204, 10'h208, 10'h300, 10'h380: legal_code = 1'b1;
            default:                                              legal_code = one_hot;
        endcase
    endfunction
`endif

    always_comb begin
        sync1_d     = btn_raw;
        s_d         = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        snap_d      = snap_q;
        button_d    = 10'h000;
        btn_valid_d = 1'b0;
`ifdef BTN_CHORD_VALIDATE_EN
        err_d       = 1'b0;
`endif
        // Saturating increment: the counter must never wrap back to zero.
        cnt_inc     = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (s_q != 10'h000) begin
                    state_d = ST_ARM;
                    snap_d  = s_q;
                    cnt_d   = '0;
                end
            end
            ST_ARM: begin
                if (s_q == 10'h000) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (s_q != snap_q) begin
                    // Chord still changing: restart the settle window on the new pattern.
                    snap_d = s_q;
                    cnt_d  = '0;
                end else if (cnt_q == C_SETTLE_LAST) begin
                    state_d = ST_EMIT;
                    cnt_d   = '0;
`ifdef BTN_CHORD_VALIDATE_EN
                    if (legal_code(snap_q)) begin
                        button_d    = snap_q;
                        btn_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
`else
                    button_d    = snap_q;
                    btn_valid_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_EMIT: begin
                state_d = ST_RELEASE;
                cnt_d   = '0;
            end
            ST_RELEASE: begin
                if (s_q != 10'h000) begin
                    cnt_d = '0;
                end else if (cnt_q == C_RELEASE_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            snap_q      <= 10'h000;
            sync1_q     <= 10'h000;
            s_q         <= 10'h000;
            button_q    <= 10'h000;
            btn_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            sync1_q     <= sync1_d;
            s_q         <= s_d;
            button_q    <= button_d;
            btn_valid_q <= btn_valid_d;
        end
    end

`ifdef BTN_CHORD_VALIDATE_EN
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign button    = button_q;
    assign btn_valid = btn_valid_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_button_chord_debounce.sv
// ============================================================================
// Module   : tb_button_chord_debounce
// Purpose  : Self-checking bench for button_chord_debounce (SETTLE=RELEASE=4).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_button_chord_debounce;

    localparam int S = 4;
    localparam int R = 4;

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic [9:0] btn_raw = 10'h000;
    logic [9:0] button;
    logic       btn_valid;
    logic       busy;
    logic       err;

    button_chord_debounce #(
        .SETTLE_CYCLES (S),
        .RELEASE_CYCLES(R),
        .CNT_W         (4)
    ) dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .btn_raw  (btn_raw),
        .button   (button),
        .btn_valid(btn_valid),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: synchronizer pipe plus run-length view of the pattern.
    logic [9:0] m1, m2, runpat;
    int         run, lock, zc;
    logic [9:0] e_btn;
    logic       e_val, e_busy, e_err;

    int         pulses, errs, busy_hi, busy_lo;
    logic [9:0] last_pat;

    typedef struct {
        logic [9:0] raw;
        logic [9:0] b;
        logic       v;
        logic       bz;
    } vec_t;
    vec_t vecs[18];

    logic [9:0] chords[6];
    int         sel, hold;
    logic [9:0] pat;

    function automatic bit legal(input logic [9:0] p);
        if ($countones(p) == 1) return 1'b1;
        case (p)
            10'h201, 10'h202, 10'h204, 10'h208, 10'h300, 10'h380: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m1 = 0; m2 = 0; runpat = 0; run = 0; lock = 0; zc = 0;
        e_btn = 0; e_val = 0; e_busy = 0; e_err = 0;
    endtask

    // Press accepted once a pattern is seen S+1 edges in a row; the next edge
    // is ignored, then R consecutive all-zero edges are needed to re-arm.
    task automatic model_edge(input logic [9:0] raw);
        logic [9:0] s;
        s  = m2;
        m2 = m1;
        m1 = raw;
        e_btn = 0; e_val = 0; e_err = 0;
        if (lock == 1) begin
            lock = 2;
            zc   = 0;
        end else if (lock == 2) begin
            if (s == 0) begin
                zc++;
                if (zc == R) lock = 0;
            end else begin
                zc = 0;
            end
        end else begin
            if (s != 0 && s == runpat) run++;
            else begin
                runpat = s;
                run    = (s != 0) ? 1 : 0;
            end
            if (run == S + 1) begin
`ifdef BTN_CHORD_VALIDATE_EN
                if (legal(runpat)) begin
                    e_btn = runpat;
                    e_val = 1;
                end else begin
                    e_err = 1;
                end
`else
                e_btn = runpat;
                e_val = 1;
`endif
                lock   = 1;
                run    = 0;
                runpat = 0;
            end
        end
        e_busy = (lock != 0) || (run != 0);
    endtask

    task automatic step(input logic [9:0] raw);
        @(negedge clk);
        btn_raw = raw;
        @(posedge clk);
        model_edge(raw);
        #1;
        chk("button", button, e_btn);
        chk("btn_valid", btn_valid, e_val);
        chk("busy", busy, e_busy);
        chk("err", err, e_err);
        if (btn_valid) begin
            pulses++;
            last_pat = button;
        end
        if (err) errs++;
        if (busy) busy_hi++; else busy_lo++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        clear_n = 1'b0;
        #1;
        chk("rst_button", button, 0);
        chk("rst_valid", btn_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        model_reset();
        @(posedge clk);
        #2;
        clear_n = 1'b1;
    endtask

    task automatic hold_pat(input logic [9:0] p, input int n);
        for (int i = 0; i < n; i++) step(p);
    endtask

    task automatic clr_counts();
        pulses = 0; errs = 0; busy_hi = 0; busy_lo = 0; last_pat = 0;
    endtask

    initial begin
        // Single key 0x004: pulse after step 6, busy from step 2 through step 14.
        for (int i = 0; i < 18; i++) begin
            vecs[i].raw = (i < 10) ? 10'h004 : 10'h000;
            vecs[i].b   = (i == 6) ? 10'h004 : 10'h000;
            vecs[i].v   = (i == 6);
            vecs[i].bz  = (i >= 2 && i <= 14);
        end
        chords[0] = 10'h201; chords[1] = 10'h202; chords[2] = 10'h204;
        chords[3] = 10'h208; chords[4] = 10'h300; chords[5] = 10'h380;

        model_reset();
        clr_counts();
        repeat (2) @(posedge clk);
        #1;
        chk("init_button", button, 0);
        chk("init_valid", btn_valid, 0);
        chk("init_busy", busy, 0);
        chk("init_err", err, 0);
        #1;
        clear_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].raw);
            chk("tbl_button", button, vecs[i].b);
            chk("tbl_valid", btn_valid, vecs[i].v);
            chk("tbl_busy", busy, vecs[i].bz);
        end

        // Chord grows from 0x200 to 0x208: only the final chord is emitted.
        clr_counts();
        hold_pat(10'h200, 2);
        hold_pat(10'h208, 20);
        hold_pat(10'h000, 10);
        chk("grow_pulses", pulses, 1);
        chk("grow_pattern", last_pat, 10'h208);

        // Toggling every cycle never settles; the FSM bounces IDLE <-> ARM.
        clr_counts();
        for (int i = 0; i < 30; i++) step((i % 2 == 0) ? 10'h001 : 10'h000);
        hold_pat(10'h000, 4);
        chk("toggle_pulses", pulses, 0);
        chk("toggle_osc", (busy_hi > 0) && (busy_lo > 0), 1);

        // Held chord gives one pulse; a short release does not re-arm.
        clr_counts();
        hold_pat(10'h380, 50);
        hold_pat(10'h000, 3);
        hold_pat(10'h380, 20);
        hold_pat(10'h000, 10);
        chk("hold_pulses", pulses, 1);
        hold_pat(10'h380, 20);
        hold_pat(10'h000, 10);
        chk("repress_pulses", pulses, 2);
        chk("repress_pattern", last_pat, 10'h380);

        // Reset in the middle of ARM discards the pending press.
        clr_counts();
        hold_pat(10'h010, 4);
        chk("pre_rst_busy", busy, 1);
        apply_reset();
        hold_pat(10'h010, 20);
        hold_pat(10'h000, 10);
        chk("rst_pulses", pulses, 1);
        chk("rst_pattern", last_pat, 10'h010);

        // Illegal chord 0x003.
        clr_counts();
        hold_pat(10'h003, 20);
        hold_pat(10'h000, 10);
`ifdef BTN_CHORD_VALIDATE_EN
        chk("illegal_err", errs, 1);
        chk("illegal_pulses", pulses, 0);
`else
        chk("chord_pulses", pulses, 1);
        chk("chord_pattern", last_pat, 10'h003);
        chk("chord_err", errs, 0);
`endif
        chk("idle_busy", busy, 0);

        // Randomized patterns and hold lengths against the model.
        for (int it = 0; it < 300; it++) begin
            sel  = $urandom_range(0, 9);
            hold = $urandom_range(1, 12);
            if (sel < 3)      pat = 10'h000;
            else if (sel < 6) pat = 10'h001 << $urandom_range(0, 9);
            else if (sel < 8) pat = chords[$urandom_range(0, 5)];
            else              pat = 10'($urandom);
            if ($urandom_range(0, 49) == 0) apply_reset();
            hold_pat(pat, hold);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
